alu_driver: RTL and testbench

Initiator-side front end for the single-cycle combinational `alu`: accepts operation requests over a valid/ready handshake, buffers them in a 4-entry FIFO, and drives the ALU operand/opcode ports from registers. It captures `Result` and the three status flags into a response register returned over a second valid/ready handshake. It sits between the issuing logic (test sequencer or execute stage) and the `alu` instance. It also rejects undefined opcodes and keeps a sticky overflow flag.

---
 rtl/alu_driver.sv | 110 +++++++++++
 tb/tb_alu_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// alu_driver: FIFO-buffered valid/ready front end that drives a combinational ALU and returns registered responses.
module alu_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_A,
    input  logic [DATA_WIDTH-1:0] req_B,
    input  logic [2:0]            req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic [2:0]            resp_flags,
    output logic                  resp_err,
    output logic                  sticky_ovf,
    input  logic                  clear_sticky,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_ALUop,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Overflow,
    input  logic                  alu_CarryOut,
    input  logic                  alu_Zero
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_d;
    logic [DATA_WIDTH-1:0] fifo_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_b [FIFO_DEPTH];
    logic [2:0]            fifo_op [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic push, pop, empty, capture, err_q, head_err;
    logic [2:0] head_op;
    assign empty     = count == '0;
    assign req_ready = count != (AW+1)'(FIFO_DEPTH);
    assign push      = req_valid & req_ready;
    assign head_op   = fifo_op[rd_ptr];
    assign head_err  = head_op inside {3'b011, 3'b100, 3'b101};
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_a[wr_ptr]  <= req_A;
                fifo_b[wr_ptr]  <= req_B;
                fifo_op[wr_ptr] <= req_op;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = empty ? IDLE : EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = resp_ready ? (empty ? IDLE : EXEC) : RESP;
            default: state_d = IDLE;
        endcase
    end
    // resp_valid is always high in RESP, so resp_ready alone completes the handshake there
    always_comb begin
        pop     = !empty && (state == IDLE || (state == RESP && resp_ready));
        capture = state == EXEC;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_A       <= '0;
            alu_B       <= '0;
            alu_ALUop   <= '0;
            err_q       <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp_err    <= 1'b0;
            sticky_ovf  <= 1'b0;
        end else begin
            if (pop) begin
                alu_A     <= fifo_a[rd_ptr];
                alu_B     <= fifo_b[rd_ptr];
                alu_ALUop <= head_err ? 3'b000 : head_op;
                err_q     <= head_err;
            end
            if (capture) begin
                resp_valid  <= 1'b1;
                resp_result <= err_q ? '0 : alu_Result;
                resp_flags  <= err_q ? 3'b000 : {alu_Overflow, alu_CarryOut, alu_Zero};
                resp_err    <= err_q;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
            sticky_ovf <= (capture && (alu_ALUop == 3'b010 || alu_ALUop == 3'b110) && alu_Overflow) ? 1'b1 :
                          clear_sticky ? 1'b0 : sticky_ovf;
        end
    end
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed-vector bench for alu_driver with a behavioural ALU attached.
module tb_alu_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_A = '0, req_B = '0;
    logic [2:0]  req_op = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic [2:0]  resp_flags;
    logic        resp_err, sticky_ovf, clear_sticky = 1'b0;
    logic [31:0] alu_A, alu_B, alu_Result;
    logic [2:0]  alu_ALUop;
    logic        alu_Overflow, alu_CarryOut, alu_Zero;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_driver #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
        .sticky_ovf(sticky_ovf), .clear_sticky(clear_sticky),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
        .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
        .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero)
    );

    // Behavioural ALU: CarryOut is the add carry or the subtract borrow
    always_comb begin
        alu_Result   = '0;
        alu_Overflow = 1'b0;
        alu_CarryOut = 1'b0;
        case (alu_ALUop)
            3'b000: alu_Result = alu_A & alu_B;
            3'b001: alu_Result = alu_A | alu_B;
            3'b010: begin
                {alu_CarryOut, alu_Result} = {1'b0, alu_A} + {1'b0, alu_B};
                alu_Overflow = (alu_A[31] == alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            3'b110: begin
                alu_Result   = alu_A - alu_B;
                alu_CarryOut = alu_A < alu_B;
                alu_Overflow = (alu_A[31] != alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            3'b111: alu_Result = {31'b0, $signed(alu_A) < $signed(alu_B)};
            default: alu_Result = '0;
        endcase
        alu_Zero = alu_Result == '0;
    end

    task automatic issue_one(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, output int lat);
        req_A = a; req_B = b; req_op = op; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        vectors++; if ({resp_result, resp_flags, resp_err, sticky_ovf} !== '0) begin miscompares++; $display("FAIL reset_resp: got %h/%b/%b/%b expected all 0", resp_result, resp_flags, resp_err, sticky_ovf); end
        vectors++; if ({alu_A, alu_B, alu_ALUop} !== '0) begin miscompares++; $display("FAIL reset_alu: got %h/%h/%b expected all 0", alu_A, alu_B, alu_ALUop); end
    endtask

    task automatic test_add();
        int lat;
        issue_one(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL add_latency: got %0d expected 2", lat); end
        vectors++; if (resp_result !== 32'h8000_0000) begin miscompares++; $display("FAIL add_result: got %h expected 80000000", resp_result); end
        vectors++; if (resp_flags !== 3'b100) begin miscompares++; $display("FAIL add_flags: got %b expected 100", resp_flags); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL add_err: got %b expected 0", resp_err); end
        vectors++; if (sticky_ovf !== 1'b1) begin miscompares++; $display("FAIL add_sticky: got %b expected 1", sticky_ovf); end
        vectors++; if ({alu_A, alu_B, alu_ALUop} !== {32'h7FFF_FFFF, 32'h1, 3'b010}) begin miscompares++; $display("FAIL add_alu_ports: got %h/%h/%b expected 7fffffff/00000001/010", alu_A, alu_B, alu_ALUop); end
        consume();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL add_resp_drop: got %b expected 0", resp_valid); end
    endtask

    task automatic test_undef();
        int lat;
        issue_one(32'd3, 32'd4, 3'b011, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL undef_latency: got %0d expected 2", lat); end
        vectors++; if ({resp_result, resp_flags, resp_err} !== {32'h0, 3'b000, 1'b1}) begin miscompares++; $display("FAIL undef011_resp: got %h/%b/%b expected 00000000/000/1", resp_result, resp_flags, resp_err); end
        vectors++; if (alu_ALUop !== 3'b000) begin miscompares++; $display("FAIL undef_aluop: got %b expected 000", alu_ALUop); end
        vectors++; if (sticky_ovf !== 1'b1) begin miscompares++; $display("FAIL undef_sticky: got %b expected 1", sticky_ovf); end
        consume();
        issue_one(32'hF, 32'hF, 3'b101, lat);
        vectors++; if ({resp_result, resp_flags, resp_err} !== {32'h0, 3'b000, 1'b1}) begin miscompares++; $display("FAIL undef101_resp: got %h/%b/%b expected 00000000/000/1", resp_result, resp_flags, resp_err); end
        vectors++; if (alu_A !== 32'hF) begin miscompares++; $display("FAIL undef101_alu_a: got %h expected 0000000f", alu_A); end
        consume();
    endtask

    task automatic test_sub_clear();
        int lat;
        issue_one(32'd5, 32'd5, 3'b110, lat);
        vectors++; if (resp_result !== 32'h0) begin miscompares++; $display("FAIL sub_result: got %h expected 00000000", resp_result); end
        vectors++; if (resp_flags !== 3'b001) begin miscompares++; $display("FAIL sub_flags: got %b expected 001", resp_flags); end
        vectors++; if (sticky_ovf !== 1'b1) begin miscompares++; $display("FAIL sub_sticky_hold: got %b expected 1", sticky_ovf); end
        consume();
        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        vectors++; if (sticky_ovf !== 1'b0) begin miscompares++; $display("FAIL sticky_clear: got %b expected 0", sticky_ovf); end
    endtask

    task automatic test_sticky_race();
        int lat;
        clear_sticky = 1'b1;
        issue_one(32'h8000_0000, 32'h0000_0001, 3'b110, lat);
        vectors++; if (sticky_ovf !== 1'b1) begin miscompares++; $display("FAIL sticky_set_wins: got %b expected 1", sticky_ovf); end
        vectors++; if (resp_result !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL sub_ovf_result: got %h expected 7fffffff", resp_result); end
        consume();
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        vectors++; if (sticky_ovf !== 1'b0) begin miscompares++; $display("FAIL sticky_clear2: got %b expected 0", sticky_ovf); end
    endtask

    task automatic test_slt();
        int lat;
        issue_one(32'hFFFF_FFFF, 32'd1, 3'b111, lat);
        vectors++; if (resp_result !== 32'd1) begin miscompares++; $display("FAIL slt_result: got %h expected 00000001", resp_result); end
        vectors++; if (resp_flags !== 3'b000) begin miscompares++; $display("FAIL slt_flags: got %b expected 000", resp_flags); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] fa [6] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60};
        logic [31:0] fb [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        logic [31:0] fr [5] = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
        int times [5];
        int idx = 0;
        int got = 0;
        logic rdy;
        for (int c = 0; c < 8; c++) begin
            req_valid = idx < 6;
            if (idx < 6) begin req_A = fa[idx]; req_B = fb[idx]; req_op = 3'b010; end
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy && idx < 6) idx++;
        end
        vectors++; if (idx !== 5) begin miscompares++; $display("FAIL full_accepted: got %0d expected 5", idx); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_req_ready: got %b expected 0", req_ready); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if ({resp_valid, resp_result, resp_flags} !== {1'b1, 32'd11, 3'b000}) begin miscompares++; $display("FAIL full_hold: got %b/%h/%b expected 1/0000000b/000", resp_valid, resp_result, resp_flags); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_still_full: got %b expected 0", req_ready); end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid) begin
                if (got < 5) begin
                    vectors++; if (resp_result !== fr[got]) begin miscompares++; $display("FAIL drain_result%0d: got %h expected %h", got, resp_result, fr[got]); end
                    times[got] = c;
                end
                got++;
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        vectors++; if (got !== 5) begin miscompares++; $display("FAIL drain_count: got %0d expected 5", got); end
        if (got == 5)
            for (int k = 1; k < 5; k++) begin
                vectors++; if (times[k] - times[k-1] !== 2) begin miscompares++; $display("FAIL drain_spacing%0d: got %0d expected 2", k, times[k] - times[k-1]); end
            end
    endtask

    task automatic test_rst_mid();
        logic [31:0] ra [4] = '{32'h7FFF_FFFF, 32'hFF, 32'hF0, 32'h0F};
        logic [31:0] rb [4] = '{32'h1, 32'hFF, 32'hFF, 32'hFF};
        logic [2:0]  ro [4] = '{3'b010, 3'b000, 3'b000, 3'b000};
        int seen = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_A = ra[i]; req_B = rb[i]; req_op = ro[i];
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        vectors++; if ({resp_valid, sticky_ovf, resp_result} !== {1'b1, 1'b1, 32'h8000_0000}) begin miscompares++; $display("FAIL rstmid_pre: got %b/%b/%h expected 1/1/80000000", resp_valid, sticky_ovf, resp_result); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if ({resp_valid, req_ready} !== 2'b01) begin miscompares++; $display("FAIL rstmid_handshake: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready); end
        vectors++; if ({resp_result, resp_flags, resp_err, sticky_ovf, alu_A, alu_B, alu_ALUop} !== '0) begin miscompares++; $display("FAIL rstmid_outputs: got %h/%b/%b/%b/%h/%h/%b expected all 0", resp_result, resp_flags, resp_err, sticky_ovf, alu_A, alu_B, alu_ALUop); end
        resp_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        resp_ready = 1'b0;
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rstmid_stale: got %0d responses expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_undef();
        test_sub_clear();
        test_sticky_race();
        test_slt();
        test_back_to_back();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
